// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, register constants, decode and bundle types.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RSV  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    localparam logic [2:0] R7 = 3'd7;

    typedef struct packed {
        logic [3:0]  op;
        logic        mode;
        logic [2:0]  nzp;
        logic        src1_en;
        logic [2:0]  src1;
        logic        src2_en;
        logic [2:0]  src2;
        logic        dr_en;
        logic [2:0]  dr;
        logic [15:0] imm;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [3:0]  op;
        logic        mode;
        logic [2:0]  nzp;
        logic [2:0]  dr;
        logic        dr_en;
        logic [15:0] src1;
        logic [15:0] src2;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        ill;
    } ex_bundle_t;

    // Sign-extend the low 'width' bits of raw to 16 bits.
    function automatic logic [15:0] sext(input logic [15:0] raw, input logic [4:0] width);
        logic [4:0]         sh;
        logic signed [15:0] tmp;
        sh  = 5'd16 - width;
        tmp = raw << sh;
        return tmp >>> sh;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch, register-read, writeback-snoop and execute signals of the decode stage.
interface id_stage_if;
    logic        inst_vld_i_w;
    logic        inst_rdy_o_w;
    logic [15:0] inst_i_w;
    logic [15:0] pc_i_w;
    logic        r_en1_o_w;
    logic [2:0]  r_addr1_o_w;
    logic [15:0] r_dat1_i_w;
    logic        r_en2_o_w;
    logic [2:0]  r_addr2_o_w;
    logic [15:0] r_dat2_i_w;
    logic        wb_en_i_w;
    logic [2:0]  wb_addr_i_w;
    logic        ex_vld_o_r;
    logic        ex_rdy_i_w;
    logic [3:0]  ex_op_o_r;
    logic        ex_mode_o_r;
    logic [2:0]  ex_nzp_o_r;
    logic [2:0]  ex_dr_o_r;
    logic        ex_dr_en_o_r;
    logic [15:0] ex_src1_o_r;
    logic [15:0] ex_src2_o_r;
    logic [15:0] ex_imm_o_r;
    logic [15:0] ex_pc_o_r;
    logic        ex_ill_o_r;

    modport master (
        input  inst_vld_i_w, inst_i_w, pc_i_w, r_dat1_i_w, r_dat2_i_w,
               wb_en_i_w, wb_addr_i_w, ex_rdy_i_w,
        output inst_rdy_o_w, r_en1_o_w, r_addr1_o_w, r_en2_o_w, r_addr2_o_w,
               ex_vld_o_r, ex_op_o_r, ex_mode_o_r, ex_nzp_o_r, ex_dr_o_r,
               ex_dr_en_o_r, ex_src1_o_r, ex_src2_o_r, ex_imm_o_r, ex_pc_o_r, ex_ill_o_r
    );

    modport slave (
        output inst_vld_i_w, inst_i_w, pc_i_w, r_dat1_i_w, r_dat2_i_w,
               wb_en_i_w, wb_addr_i_w, ex_rdy_i_w,
        input  inst_rdy_o_w, r_en1_o_w, r_addr1_o_w, r_en2_o_w, r_addr2_o_w,
               ex_vld_o_r, ex_op_o_r, ex_mode_o_r, ex_nzp_o_r, ex_dr_o_r,
               ex_dr_en_o_r, ex_src1_o_r, ex_src2_o_r, ex_imm_o_r, ex_pc_o_r, ex_ill_o_r
    );
endinterface

// File: rtl/id_decode.sv
// Combinational LC-3 field decode: sources, destination, immediate and flags.
module id_decode
    import lc3_pkg::*;
(
    input  logic [15:0] inst_i,
    output dec_t        dec_o
);

    opcode_e op_s;
    assign op_s = opcode_e'(inst_i[15:12]);

    // Per-opcode selection; unused fields stay zero
    always_comb begin
        dec_o    = '0;
        dec_o.op = inst_i[15:12];
        case (op_s)
            OP_ADD, OP_AND: begin
                dec_o.mode    = inst_i[5];
                dec_o.src1_en = 1'b1;
                dec_o.src1    = inst_i[8:6];
                dec_o.dr_en   = 1'b1;
                dec_o.dr      = inst_i[11:9];
                if (inst_i[5]) begin
                    dec_o.imm = sext({11'd0, inst_i[4:0]}, 5'd5);
                end else begin
                    dec_o.src2_en = 1'b1;
                    dec_o.src2    = inst_i[2:0];
                end
            end
            OP_NOT: begin
                dec_o.src1_en = 1'b1;
                dec_o.src1    = inst_i[8:6];
                dec_o.dr_en   = 1'b1;
                dec_o.dr      = inst_i[11:9];
            end
            OP_BR: begin
                dec_o.nzp = inst_i[11:9];
                dec_o.imm = sext({7'd0, inst_i[8:0]}, 5'd9);
            end
            OP_LD, OP_LDI, OP_LEA: begin
                dec_o.dr_en = 1'b1;
                dec_o.dr    = inst_i[11:9];
                dec_o.imm   = sext({7'd0, inst_i[8:0]}, 5'd9);
            end
            OP_ST, OP_STI: begin
                dec_o.src2_en = 1'b1;
                dec_o.src2    = inst_i[11:9];
                dec_o.imm     = sext({7'd0, inst_i[8:0]}, 5'd9);
            end
            OP_LDR: begin
                dec_o.src1_en = 1'b1;
                dec_o.src1    = inst_i[8:6];
                dec_o.dr_en   = 1'b1;
                dec_o.dr      = inst_i[11:9];
                dec_o.imm     = sext({10'd0, inst_i[5:0]}, 5'd6);
            end
            OP_STR: begin
                dec_o.src1_en = 1'b1;
                dec_o.src1    = inst_i[8:6];
                dec_o.src2_en = 1'b1;
                dec_o.src2    = inst_i[11:9];
                dec_o.imm     = sext({10'd0, inst_i[5:0]}, 5'd6);
            end
            OP_JSR: begin
                dec_o.mode  = inst_i[11];
                dec_o.dr_en = 1'b1;
                dec_o.dr    = R7;
                if (inst_i[11]) begin
                    dec_o.imm = sext({5'd0, inst_i[10:0]}, 5'd11);
                end else begin
                    dec_o.src1_en = 1'b1;
                    dec_o.src1    = inst_i[8:6];
                end
            end
            OP_JMP: begin
                dec_o.src1_en = 1'b1;
                dec_o.src1    = inst_i[8:6];
            end
            OP_TRAP: begin
                dec_o.dr_en = 1'b1;
                dec_o.dr    = R7;
                dec_o.imm   = {8'd0, inst_i[7:0]};
            end
            OP_RTI, OP_RSV: begin
                dec_o.ill = 1'b1;
            end
            default: begin
                dec_o.ill = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// LC-3 decode/operand-fetch stage: register read requests, RAW/WAW scoreboard,
// and a registered valid/ready bundle toward execute.
module id_stage
    import lc3_pkg::*;
(
    input  logic       clk_i_w,
    input  logic       rst_i_w,
    input  logic       flush_i_w,
    id_stage_if.master bus,
    output logic [7:0] sb_busy_o_w
);

    dec_t       dec_s;
    logic       src1_en_s;
    logic       src2_en_s;
    logic       dr_en_s;
    logic       hazard_s;
    logic       accept_s;
    logic       handoff_s;
    logic [7:0] blk_s;
    logic [7:0] clr_s;
    logic [7:0] set_s;
    logic [7:0] sb_d;
    logic [7:0] sb_q;
    logic       ex_vld_d;
    logic       ex_vld_q;
    ex_bundle_t ex_d;
    ex_bundle_t ex_q;

    id_decode u_decode (
        .inst_i (bus.inst_i_w),
        .dec_o  (dec_s)
    );

    assign src1_en_s = bus.inst_vld_i_w & dec_s.src1_en;
    assign src2_en_s = bus.inst_vld_i_w & dec_s.src2_en;
    assign dr_en_s   = bus.inst_vld_i_w & dec_s.dr_en;

    assign bus.r_en1_o_w   = src1_en_s;
    assign bus.r_addr1_o_w = src1_en_s ? dec_s.src1 : 3'd0;
    assign bus.r_en2_o_w   = src2_en_s;
    assign bus.r_addr2_o_w = src2_en_s ? dec_s.src2 : 3'd0;

    assign handoff_s = ex_vld_q & bus.ex_rdy_i_w & ~flush_i_w;

    // Per-register blocking state and scoreboard update; a same-cycle set beats a clear
    always_comb begin
        blk_s = '0;
        clr_s = '0;
        set_s = '0;
        sb_d  = '0;
        for (int i = 0; i < 8; i++) begin
            clr_s[i] = bus.wb_en_i_w && (bus.wb_addr_i_w == i[2:0]);
            set_s[i] = handoff_s && ex_q.dr_en && (ex_q.dr == i[2:0]);
            blk_s[i] = (sb_q[i] && !clr_s[i]) ||
                       (ex_vld_q && ex_q.dr_en && (ex_q.dr == i[2:0]));
            sb_d[i]  = (sb_q[i] & ~clr_s[i]) | set_s[i];
        end
    end

    assign hazard_s = (src1_en_s && blk_s[dec_s.src1]) ||
                      (src2_en_s && blk_s[dec_s.src2]) ||
                      (dr_en_s   && blk_s[dec_s.dr]);

    assign bus.inst_rdy_o_w = !hazard_s && (!ex_vld_q || bus.ex_rdy_i_w) && !flush_i_w;
    assign accept_s         = bus.inst_vld_i_w && bus.inst_rdy_o_w;

    // Output register next state: flush kills, accept loads, bare handoff empties
    always_comb begin
        ex_d     = ex_q;
        ex_vld_d = ex_vld_q;
        if (flush_i_w) begin
            ex_vld_d = 1'b0;
        end else if (accept_s) begin
            ex_vld_d   = 1'b1;
            ex_d.op    = dec_s.op;
            ex_d.mode  = dec_s.mode;
            ex_d.nzp   = dec_s.nzp;
            ex_d.dr    = dec_s.dr;
            ex_d.dr_en = dec_s.dr_en;
            ex_d.src1  = dec_s.src1_en ? bus.r_dat1_i_w : 16'h0000;
            ex_d.src2  = dec_s.src2_en ? bus.r_dat2_i_w : 16'h0000;
            ex_d.imm   = dec_s.imm;
            ex_d.pc    = bus.pc_i_w;
            ex_d.ill   = dec_s.ill;
        end else if (handoff_s) begin
            ex_vld_d = 1'b0;
        end else begin
            ex_vld_d = ex_vld_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            ex_q     <= '0;
            ex_vld_q <= 1'b0;
            sb_q     <= 8'h00;
        end else begin
            ex_q     <= ex_d;
            ex_vld_q <= ex_vld_d;
            sb_q     <= sb_d;
        end
    end

    assign bus.ex_vld_o_r   = ex_vld_q;
    assign bus.ex_op_o_r    = ex_q.op;
    assign bus.ex_mode_o_r  = ex_q.mode;
    assign bus.ex_nzp_o_r   = ex_q.nzp;
    assign bus.ex_dr_o_r    = ex_q.dr;
    assign bus.ex_dr_en_o_r = ex_q.dr_en;
    assign bus.ex_src1_o_r  = ex_q.src1;
    assign bus.ex_src2_o_r  = ex_q.src2;
    assign bus.ex_imm_o_r   = ex_q.imm;
    assign bus.ex_pc_o_r    = ex_q.pc;
    assign bus.ex_ill_o_r   = ex_q.ill;
    assign sb_busy_o_w      = sb_q;

endmodule

// File: doc/id_stage.md
# id_stage

LC-3 decode/operand-fetch stage: the requester for the core register file's two read ports. It accepts one instruction per cycle from fetch and decodes it. It drives `regs` read enables and addresses, captures the returned operands, and presents a registered bundle to execute over a valid/ready handshake. An internal per-register scoreboard snoops the writeback port and stalls RAW/WAW hazards.

## Interface
- No parameters; widths fixed by LC-3 (16-bit data, 3-bit register index).
- One clock; reset is asynchronous and active-low.
- `clk_i_w` in 1: clock.
- `rst_i_w` in 1: asynchronous, active-low reset.
- `flush_i_w` in 1: kill the output bundle and refuse input this cycle.
- `inst_vld_i_w` in 1: fetch bundle valid.
- `inst_rdy_o_w` out 1: stage accepts instruction.
- `inst_i_w` in 16: instruction.
- `pc_i_w` in 16: incremented PC of instruction.
- `r_en1_o_w` out 1, `r_addr1_o_w` out 3: read port 1 request (SR1/BaseR).
- `r_dat1_i_w` in 16: port 1 data (combinational, write-bypassed).
- `r_en2_o_w` out 1, `r_addr2_o_w` out 3: read port 2 request (SR2 / store source).
- `r_dat2_i_w` in 16: port 2 data.
- `wb_en_i_w` in 1, `wb_addr_i_w` in 3: snoop of the register-file write port.
- `ex_vld_o_r` out 1, `ex_rdy_i_w` in 1: output handshake.
- `ex_op_o_r` out 4: opcode.
- `ex_mode_o_r` out 1: inst[5] for ADD/AND, inst[11] for JSR; else 0.
- `ex_nzp_o_r` out 3: inst[11:9] for BR; else 0.
- `ex_dr_o_r` out 3, `ex_dr_en_o_r` out 1: destination register and its enable.
- `ex_src1_o_r` out 16, `ex_src2_o_r` out 16: operands.
- `ex_imm_o_r` out 16: extended immediate/offset.
- `ex_pc_o_r` out 16: PC.
- `ex_ill_o_r` out 1: RTI or reserved opcode 1101.
- `sb_busy_o_w` out 8: scoreboard pending bits.

## Operation
- Sources:
  - Port 1 = inst[8:6] for ADD, AND, NOT, JMP, JSRR (inst[11]=0), LDR, STR.
  - Port 2 = inst[2:0] for ADD/AND with inst[5]=0.
  - Port 2 = inst[11:9] for ST, STI, STR.
  - Unused port: `r_en` low, address 0, captured operand 0.
- Destination:
  - DR = inst[11:9] for ADD, AND, NOT, LD, LDI, LDR, LEA.
  - DR = 7 for JSR/JSRR and TRAP.
  - All other opcodes: `dr_en`=0.
- Immediate:
  - sext(inst[4:0]) for ADD/AND imm mode.
  - sext(inst[5:0]) for LDR/STR.
  - sext(inst[8:0]) for BR, LD, LDI, ST, STI, LEA.
  - sext(inst[10:0]) for JSR.
  - zext(inst[7:0]) for TRAP.
  - Otherwise 0.
- RTI and opcode 1101: `ex_ill_o_r`=1, no sources, no destination.
- Read requests are driven combinationally from `inst_i_w` whenever `inst_vld_i_w` is high.
- Hazard when any enabled source or the enabled destination is:
  - set in the scoreboard and not being cleared this cycle (`wb_en_i_w` && `wb_addr_i_w` matches), or
  - equal to `ex_dr_o_r` while `ex_vld_o_r` && `ex_dr_en_o_r`.
- `inst_rdy_o_w` = !hazard && (!`ex_vld_o_r` || `ex_rdy_i_w`) && !`flush_i_w`.
- Accept (`inst_vld_i_w` && `inst_rdy_o_w`): at the next edge the bundle, including `r_dat1_i_w`/`r_dat2_i_w`, loads into the output register and `ex_vld_o_r` goes to 1.
- Output register: held while `ex_vld_o_r` && !`ex_rdy_i_w`. Handoff without a new accept clears `ex_vld_o_r`.
- Scoreboard:
  - Set bit DR on handoff (`ex_vld_o_r` && `ex_rdy_i_w` && `ex_dr_en_o_r`).
  - Clear bit `wb_addr_i_w` on `wb_en_i_w`.
  - Set and clear of the same bit in one cycle: set wins.
- Flush: `ex_vld_o_r`→0 at the next edge; no handoff counts that cycle; scoreboard unchanged.

## Timing
- Latency: accept at edge N, `ex_vld_o_r`=1 after edge N.
- Throughput: 1 instruction/cycle absent hazards and backpressure.
- Writeback release: a stalled instruction is accepted in the same cycle `wb_en_i_w` clears its blocking register. Operand forwarding is done by `regs`.
- Reset (any time, including mid-stall): all `ex_*` outputs 0, scoreboard 0, `ex_vld_o_r` 0. `inst_rdy_o_w` is 1 whenever `flush_i_w` is low.
- Output bundle is stable while `ex_vld_o_r` && !`ex_rdy_i_w`.

## Structure
- Shared `lc3_pkg`:
  - opcode constants (OP_BR … OP_TRAP, OP_RSV = 4'b1101);
  - R7 index constant;
  - sign-extension helper.
- Sub-module `id_decode`: purely combinational field/source/dest/immediate decode.
- Top level holds hazard logic, the output register and the scoreboard.

## Test plan
- ADD R1,R2,#-1 (0x12BF): `r_addr1`=2, `r_en2`=0, next cycle `ex_dr`=1, `ex_imm`=0xFFFF, `ex_mode`=1.
- STR R4,R5,#-2 (0x797E): `r_addr1`=5, `r_addr2`=4, `ex_imm`=0xFFFE, `ex_dr_en`=0.
- ADD R1,R2,#-1 handed off, then ADD R3,R1,R1 (0x1641):
  - `inst_rdy` low while `sb_busy[1]`=1;
  - `wb_en`=1/addr 1 raises `inst_rdy` that cycle;
  - `ex_src1` = written value.
- TRAP x25 (0xF025) then ADD R7,R0,R0 (0x1E00): first gives `ex_dr`=7, `ex_imm`=0x0025; second stalls on WAW until wb to R7.
- `ex_rdy`=0 for 3 cycles: bundle held; `flush_i_w` then clears `ex_vld`, and `sb_busy` is unchanged.
- Reset asserted mid-stall with `sb_busy`=0x02: all outputs 0, `sb_busy`=0; 0x1641 accepted in the first cycle after release.
